memwb_stage: RTL and testbench
==============================

Name: memwb_stage

Overview:
- Parametrised MEM/WB pipeline stage for the RV32 core.
- Sits between the data-memory stage and the register-file write port.
- Carries ALU result, load data, PC+4, destination register and writeback controls, and selects the final writeback value.
- Adds valid/ready flow control with a 2-entry skid buffer, flush, and bubble-safe write enable.

Parameters:
- XLEN, 32, datapath width of alu_out, mem_rdata, pc_incr and wb_data.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid_i  in  1  MEM stage presents a valid bundle.
- in_ready_o  out  1  stage can accept a bundle this cycle.
- alu_out_i  in  XLEN  ALU result.
- mem_rdata_i  in  XLEN  raw data-memory read word.
- pc_incr_i  in  XLEN  PC+4 of the instruction.
- rd_i  in  RD_W  destination register.
- reg_write_i  in  1  instruction writes the register file.
- wb_sel_i  in  2  writeback source: 00 ALU, 01 memory, 10 PC+4, 11 zero.
- funct3_i  in  3  load type; used only with the optional feature.
- flush_i  in  1  discard all held and incoming bundles.
- out_valid_o  out  1  WB bundle valid.
- out_ready_i  in  1  WB consumer accepts the bundle.
- wb_data_o  out  XLEN  selected writeback value.
- rd_o  out  RD_W  destination register.
- reg_write_o  out  1  qualified register-file write enable.

Behaviour:
- Storage: one main register M (feeds outputs) and one skid register S; each has a valid bit.
- Accept: in_valid_i & in_ready_o. Drain: out_valid_o & out_ready_i.
- in_ready_o = ~S.valid & ~rst. It is a registered-state function with no combinational path from out_ready_i.
- Accept when M is empty or draining: the bundle loads M; out_valid_o is 1 next cycle. Latency is 1 cycle.
- Accept when M is full and not draining: the bundle loads S; in_ready_o is 0 next cycle.
- Drain while S is valid: S moves to M and S.valid clears, so in_ready_o returns to 1 the next cycle.
- Drain while S is valid with a simultaneous accept cannot occur, because in_ready_o = 0.
- Drain with no accept and S empty: M.valid clears.
- Ordering is strictly FIFO. No bundle is dropped or duplicated under any out_ready_i pattern.
- flush_i has top priority. Next cycle M.valid = S.valid = 0, and any bundle accepted in the flush cycle is discarded.
- During flush, data fields may hold stale values; only the valid bits are cleared.
- wb_data_o is a combinational mux of M fields by M.wb_sel: alu_out, mem_rdata (or the extended load value), pc_incr, or 0.
- reg_write_o = out_valid_o & M.reg_write & (M.rd != 0). Bubbles and x0 never write.
- rd_o = M.rd.
- Register-file write is considered to occur on a drain cycle. The consumer normally ties out_ready_i = 1.
- Reset: while rst is high, all valid bits and all data/control registers are 0. So out_valid_o = 0, wb_data_o = 0, rd_o = 0, reg_write_o = 0 and in_ready_o = 0.
- Reset asserted mid-operation loses all in-flight bundles. in_ready_o = 1 in the first cycle after rst deasserts.

Optional Feature:
- Macro: MEMWB_LOAD_EXT_EN.
- With the macro: the stage also registers alu_out_i[1:0] as the byte offset. When wb_sel = 01, mem_rdata is shifted right by 8*offset and then extended per funct3:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend halfword.
  - 010 LW: pass through.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend halfword.
  - Other funct3 values give 0.
- Without the macro: funct3_i is ignored, no offset or funct3 state exists, and mem_rdata passes through unmodified.

Test Plan:
- Reset: hold rst for 3 cycles with in_valid_i = 1. Required: out_valid_o = 0, reg_write_o = 0 and in_ready_o = 0 throughout; in_ready_o = 1 in the first cycle after release.
- Single pass: out_ready_i = 1; send alu_out = 0x0000_1234, rd = 5, wb_sel = 00, reg_write = 1. Required: one cycle later, wb_data_o = 0x1234, rd_o = 5, reg_write_o = 1 for exactly one cycle.
- Backpressure: stream bundles A, B, C with out_ready_i = 0 from cycle 1. Required: A is held in M, B goes to S, in_ready_o = 0 blocks C. Release out_ready_i; outputs must be A, B, C in order with no loss.
- Flush: with M and S both full, and D presented with flush_i = 1. Required: next cycle out_valid_o = 0, in_ready_o = 1, and D never appears.
- Writeback select and x0: wb_sel = 10 with pc_incr = 0x104 gives wb_data_o = 0x104. rd = 0 with reg_write = 1 gives reg_write_o = 0.
- With MEMWB_LOAD_EXT_EN: mem_rdata = 0x80FF_7F01, alu_out[1:0] = 2, funct3 = 000 gives 0xFFFF_FFFF. Same inputs with funct3 = 101 gives 0x0000_80FF.

Source files
------------

// File: rtl/memwb_stage.sv
// MEM/WB pipeline stage: holds one bundle in main register M (drives outputs)
// and one in skid register S, with valid/ready flow control, flush and a
// final writeback-source mux. Optional load extraction/extension is enabled
// by defining MEMWB_LOAD_EXT_EN.
module memwb_stage #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned RD_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [XLEN-1:0] alu_out_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   input  logic [XLEN-1:0] pc_incr_i,
   input  logic [RD_W-1:0] rd_i,
   input  logic            reg_write_i,
   input  logic [1:0]      wb_sel_i,
   input  logic [2:0]      funct3_i,
   input  logic            flush_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] wb_data_o,
   output logic [RD_W-1:0] rd_o,
   output logic            reg_write_o
);

   typedef struct packed {
      logic [XLEN-1:0] alu;
      logic [XLEN-1:0] mem;
      logic [XLEN-1:0] pc;
      logic [RD_W-1:0] rd;
      logic            rw;
      logic [1:0]      sel;
`ifdef MEMWB_LOAD_EXT_EN
      logic [1:0]      off;
      logic [2:0]      f3;
`endif
   } bundle_t;

   bundle_t r_m, r_s, w_m_next, w_s_next, w_in;
   logic    r_m_valid, r_s_valid, w_m_valid_next, w_s_valid_next;
   logic    w_accept, w_drain;
   logic    w_unused_funct3;

`ifdef MEMWB_LOAD_EXT_EN
   // Align the addressed byte/halfword to bit 0, then extend per load type.
   function automatic logic [XLEN-1:0] f_load_ext(input logic [XLEN-1:0] raw,
                                                  input logic [1:0] off,
                                                  input logic [2:0] f3);
      logic [XLEN-1:0] sh;
      sh = raw >> {off, 3'b000};
      case (f3)
         3'b000:  return {{(XLEN-8){sh[7]}}, sh[7:0]};
         3'b001:  return {{(XLEN-16){sh[15]}}, sh[15:0]};
         3'b010:  return sh;
         3'b100:  return {{(XLEN-8){1'b0}}, sh[7:0]};
         3'b101:  return {{(XLEN-16){1'b0}}, sh[15:0]};
         default: return '0;
      endcase
   endfunction
   assign w_unused_funct3 = 1'b0;
`else
   // funct3 only matters to the load-extension logic.
   assign w_unused_funct3 = ^funct3_i;
`endif

   // Ready depends only on registered state, never on out_ready_i.
   assign in_ready_o = ~r_s_valid & ~rst;
   assign w_accept   = in_valid_i & in_ready_o;
   assign w_drain    = r_m_valid & out_ready_i;

   // Pack the incoming bundle.
   always_comb begin
      w_in     = '0;
      w_in.alu = alu_out_i;
      w_in.mem = mem_rdata_i;
      w_in.pc  = pc_incr_i;
      w_in.rd  = rd_i;
      w_in.rw  = reg_write_i;
      w_in.sel = wb_sel_i;
`ifdef MEMWB_LOAD_EXT_EN
      w_in.off = alu_out_i[1:0];
      w_in.f3  = funct3_i;
`endif
   end

   // Next-state for M/S: flush clears valids only; otherwise FIFO order.
   always_comb begin
      w_m_next       = r_m;
      w_s_next       = r_s;
      w_m_valid_next = r_m_valid;
      w_s_valid_next = r_s_valid;
      if (flush_i) begin
         w_m_valid_next = 1'b0;
         w_s_valid_next = 1'b0;
      end else if (w_drain) begin
         if (r_s_valid) begin
            // Accept is impossible here since in_ready_o is low.
            w_m_next       = r_s;
            w_s_valid_next = 1'b0;
         end else if (w_accept) begin
            w_m_next = w_in;
         end else begin
            w_m_valid_next = 1'b0;
         end
      end else if (w_accept) begin
         if (!r_m_valid) begin
            w_m_next       = w_in;
            w_m_valid_next = 1'b1;
         end else begin
            w_s_next       = w_in;
            w_s_valid_next = 1'b1;
         end
      end
   end

   // State registers with asynchronous clear of all fields.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m       <= '0;
         r_s       <= '0;
         r_m_valid <= 1'b0;
         r_s_valid <= 1'b0;
      end else begin
         r_m       <= w_m_next;
         r_s       <= w_s_next;
         r_m_valid <= w_m_valid_next;
         r_s_valid <= w_s_valid_next;
      end
   end

   // Writeback source select from M.
   always_comb begin
      wb_data_o = '0;
      case (r_m.sel)
         2'b00:   wb_data_o = r_m.alu;
`ifdef MEMWB_LOAD_EXT_EN
         2'b01:   wb_data_o = f_load_ext(r_m.mem, r_m.off, r_m.f3);
`else
         2'b01:   wb_data_o = r_m.mem;
`endif
         2'b10:   wb_data_o = r_m.pc;
         default: wb_data_o = '0;
      endcase
   end

   assign out_valid_o = r_m_valid;
   assign rd_o        = r_m.rd;
   // Bubbles and x0 never write the register file.
   assign reg_write_o = r_m_valid & r_m.rw & (r_m.rd != '0);

endmodule

// File: tb/tb_memwb_stage.sv
// Self-checking bench for memwb_stage: reset, table vectors, hand-written
// backpressure/flush sequences, then random traffic against a queue model.
module tb_memwb_stage;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] mem;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        rw;
      logic [1:0]  sel;
      logic [2:0]  f3;
   } bund_t;

   typedef struct {
      bund_t       b;
      logic [31:0] e_wb;
      logic [4:0]  e_rd;
      logic        e_rw;
   } vec_t;

   logic        clk, rst;
   logic        in_valid_i, in_ready_o, flush_i, out_valid_o, out_ready_i;
   logic [31:0] alu_out_i, mem_rdata_i, pc_incr_i, wb_data_o;
   logic [4:0]  rd_i, rd_o;
   logic        reg_write_i, reg_write_o;
   logic [1:0]  wb_sel_i;
   logic [2:0]  funct3_i;

   int n_tests = 0;
   int n_fail  = 0;

   vec_t  vq[$];
   bund_t q[$];

   memwb_stage #(.XLEN(32), .RD_W(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .alu_out_i   (alu_out_i),
      .mem_rdata_i (mem_rdata_i),
      .pc_incr_i   (pc_incr_i),
      .rd_i        (rd_i),
      .reg_write_i (reg_write_i),
      .wb_sel_i    (wb_sel_i),
      .funct3_i    (funct3_i),
      .flush_i     (flush_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .wb_data_o   (wb_data_o),
      .rd_o        (rd_o),
      .reg_write_o (reg_write_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic bund_t mkb(input logic [31:0] alu, input logic [31:0] mem,
                                 input logic [31:0] pc, input logic [4:0] rd,
                                 input logic rw, input logic [1:0] sel, input logic [2:0] f3);
      bund_t b;
      b.alu = alu; b.mem = mem; b.pc = pc; b.rd = rd; b.rw = rw; b.sel = sel; b.f3 = f3;
      return b;
   endfunction

   task automatic drive(input logic v, input bund_t b);
      in_valid_i  = v;
      alu_out_i   = b.alu;
      mem_rdata_i = b.mem;
      pc_incr_i   = b.pc;
      rd_i        = b.rd;
      reg_write_i = b.rw;
      wb_sel_i    = b.sel;
      funct3_i    = b.f3;
   endtask

   task automatic add_vec(input bund_t b, input logic [31:0] wb, input logic [4:0] rd,
                          input logic rw);
      vec_t v;
      v.b = b; v.e_wb = wb; v.e_rd = rd; v.e_rw = rw;
      vq.push_back(v);
   endtask

   // Reference writeback value, computed with plain arithmetic.
   function automatic logic [31:0] model_wb(input bund_t b);
      logic [31:0] sh, byt, half;
      if (b.sel == 2'd0) return b.alu;
      if (b.sel == 2'd2) return b.pc;
      if (b.sel == 2'd3) return 32'd0;
`ifdef MEMWB_LOAD_EXT_EN
      sh   = b.mem >> (8 * b.alu[1:0]);
      byt  = sh & 32'hFF;
      half = sh & 32'hFFFF;
      if (b.f3 == 3'd0) return (byt ^ 32'h80) - 32'h80;
      if (b.f3 == 3'd1) return (half ^ 32'h8000) - 32'h8000;
      if (b.f3 == 3'd2) return sh;
      if (b.f3 == 3'd4) return byt;
      if (b.f3 == 3'd5) return half;
      return 32'd0;
`else
      sh = 32'd0; byt = 32'd0; half = sh | byt;
      return b.mem | half;
`endif
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string name);
      check({name, "_valid"}, 32'(out_valid_o), 32'd0);
      check({name, "_rw"}, 32'(reg_write_o), 32'd0);
   endtask

   initial begin
      bund_t a, bb, c, d, z;
      z = mkb(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
      drive(1'b1, mkb(32'h55, 32'h66, 32'h77, 5'd9, 1'b1, 2'd0, 3'd0));

      // Reset held 3 cycles with in_valid high.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_valid", 32'(out_valid_o), 32'd0);
         check("rst_rw", 32'(reg_write_o), 32'd0);
         check("rst_ready", 32'(in_ready_o), 32'd0);
         check("rst_wb", wb_data_o, 32'd0);
         check("rst_rd", 32'(rd_o), 32'd0);
      end
      drive(1'b0, z);
      rst = 1'b0;
      #1;
      check("rst_release_ready", 32'(in_ready_o), 32'd1);

      // Single pass, reg_write for exactly one cycle.
      drive(1'b1, mkb(32'h0000_1234, 0, 0, 5'd5, 1'b1, 2'd0, 3'd0));
      tick();
      check("single_wb", wb_data_o, 32'h1234);
      check("single_rd", 32'(rd_o), 32'd5);
      check("single_rw", 32'(reg_write_o), 32'd1);
      drive(1'b0, z);
      tick();
      check_idle("single_after");

      // Table-driven streaming vectors with out_ready tied high.
      add_vec(mkb(32'h0000_1234, 0, 0, 5'd5, 1, 2'd0, 0), 32'h0000_1234, 5'd5, 1);
      add_vec(mkb(32'h1111, 0, 32'h104, 5'd3, 1, 2'd2, 0), 32'h104, 5'd3, 1);
      add_vec(mkb(32'hDEAD, 0, 0, 5'd0, 1, 2'd0, 0), 32'hDEAD, 5'd0, 0);
      add_vec(mkb(32'hFFFF, 32'h1, 32'h2, 5'd7, 1, 2'd3, 0), 32'h0, 5'd7, 1);
      add_vec(mkb(32'h100, 32'hCAFE_BABE, 0, 5'd1, 0, 2'd1, 3'd2), 32'hCAFE_BABE, 5'd1, 0);
      add_vec(mkb(32'hA5A5, 0, 0, 5'd31, 0, 2'd0, 0), 32'hA5A5, 5'd31, 0);
`ifdef MEMWB_LOAD_EXT_EN
      add_vec(mkb(32'h2, 32'h80FF_7F01, 0, 5'd4, 1, 2'd1, 3'd0), 32'hFFFF_FFFF, 5'd4, 1);
      add_vec(mkb(32'h2, 32'h80FF_7F01, 0, 5'd4, 1, 2'd1, 3'd5), 32'h0000_80FF, 5'd4, 1);
      add_vec(mkb(32'h1, 32'h80FF_7F01, 0, 5'd6, 1, 2'd1, 3'd4), 32'h0000_007F, 5'd6, 1);
      add_vec(mkb(32'h0, 32'h80FF_7F01, 0, 5'd6, 1, 2'd1, 3'd3), 32'h0, 5'd6, 1);
`else
      add_vec(mkb(32'h2, 32'h80FF_7F01, 0, 5'd4, 1, 2'd1, 3'd0), 32'h80FF_7F01, 5'd4, 1);
      add_vec(mkb(32'h2, 32'h80FF_7F01, 0, 5'd4, 1, 2'd1, 3'd5), 32'h80FF_7F01, 5'd4, 1);
`endif
      for (int i = 0; i < vq.size(); i++) begin
         drive(1'b1, vq[i].b);
         tick();
         check("vec_valid", 32'(out_valid_o), 32'd1);
         check("vec_wb", wb_data_o, vq[i].e_wb);
         check("vec_rd", 32'(rd_o), 32'(vq[i].e_rd));
         check("vec_rw", 32'(reg_write_o), 32'(vq[i].e_rw));
      end
      drive(1'b0, z);
      tick();
      check_idle("vec_drained");

      // Backpressure: A in M, B in S, C blocked, then ordered drain.
      a  = mkb(32'hA, 0, 0, 5'd10, 1, 2'd0, 0);
      bb = mkb(32'hB, 0, 0, 5'd11, 1, 2'd0, 0);
      c  = mkb(32'hC, 0, 0, 5'd12, 1, 2'd0, 0);
      out_ready_i = 1'b0;
      drive(1'b1, a);
      tick();
      check("bp_a_wb", wb_data_o, 32'hA);
      check("bp_a_ready", 32'(in_ready_o), 32'd1);
      drive(1'b1, bb);
      tick();
      check("bp_b_ready", 32'(in_ready_o), 32'd0);
      check("bp_hold_a", wb_data_o, 32'hA);
      drive(1'b1, c);
      tick();
      check("bp_c_blocked", 32'(in_ready_o), 32'd0);
      check("bp_hold_a2", wb_data_o, 32'hA);
      out_ready_i = 1'b1;
      tick();
      check("bp_out_b", wb_data_o, 32'hB);
      check("bp_ready_back", 32'(in_ready_o), 32'd1);
      tick();
      check("bp_out_c", wb_data_o, 32'hC);
      check("bp_out_c_valid", 32'(out_valid_o), 32'd1);
      drive(1'b0, z);
      tick();
      check_idle("bp_empty");

      // Flush with M and S full while D is presented.
      out_ready_i = 1'b0;
      drive(1'b1, a);
      tick();
      drive(1'b1, bb);
      tick();
      check("fl_full", 32'(in_ready_o), 32'd0);
      d = mkb(32'hD, 0, 0, 5'd13, 1, 2'd0, 0);
      drive(1'b1, d);
      flush_i = 1'b1;
      tick();
      // D is not accepted that cycle (ready low), so present it with flush again.
      check("fl_valid", 32'(out_valid_o), 32'd0);
      check("fl_ready", 32'(in_ready_o), 32'd1);
      tick();
      check("fl_d_accept_discard", 32'(out_valid_o), 32'd0);
      flush_i = 1'b0;
      drive(1'b0, z);
      out_ready_i = 1'b1;
      tick();
      check_idle("fl_no_d");

      // Random traffic against a 2-deep FIFO model.
      for (int cyc = 0; cyc < 600; cyc++) begin
         bund_t rb;
         logic  v, r, f, e_ready, e_valid, acc, drn;
         rb = mkb($urandom, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom),
                  2'($urandom), 3'($urandom));
         if ($urandom_range(0, 3) == 0) rb.rd = 5'd0;
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) != 0);
         f = ($urandom_range(0, 24) == 0);
         drive(v, rb);
         out_ready_i = r;
         flush_i     = f;
         e_ready = (q.size() < 2);
         e_valid = (q.size() > 0);
         check("rnd_ready", 32'(in_ready_o), 32'(e_ready));
         check("rnd_valid", 32'(out_valid_o), 32'(e_valid));
         if (e_valid) begin
            check("rnd_wb", wb_data_o, model_wb(q[0]));
            check("rnd_rd", 32'(rd_o), 32'(q[0].rd));
            check("rnd_rw", 32'(reg_write_o), 32'(q[0].rw && (q[0].rd != 5'd0)));
         end else begin
            check("rnd_rw_bubble", 32'(reg_write_o), 32'd0);
         end
         acc = v && e_ready;
         drn = e_valid && r;
         tick();
         if (f) begin
            q.delete();
         end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(rb);
         end
      end

      // Reset mid-operation loses in-flight bundles.
      flush_i = 1'b0;
      out_ready_i = 1'b0;
      drive(1'b1, a);
      tick();
      rst = 1'b1;
      #1;
      check("midrst_valid", 32'(out_valid_o), 32'd0);
      check("midrst_ready", 32'(in_ready_o), 32'd0);
      tick();
      drive(1'b0, z);
      rst = 1'b0;
      #1;
      check("midrst_release_ready", 32'(in_ready_o), 32'd1);
      check("midrst_empty", 32'(out_valid_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
